// File: rtl/s_egress_arb_pkg.sv
// Shared types and the round-robin pick for the egress packet arbiter.
package s_egress_arb_pkg;

  localparam int ARB_BW    = 32;
  localparam int ARB_BWB   = ARB_BW / 8;
  localparam int ARB_N_SRC = 4;
  localparam int ARB_IDW   = $clog2(ARB_N_SRC);

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_e;

  // One beat as stored in the output FIFO.
  typedef struct packed {
    logic [ARB_BW-1:0]  data;
    logic [ARB_BWB-1:0] keep;
    logic               last;
    logic [ARB_IDW-1:0] id;
  } beat_t;

  typedef struct packed {
    logic [ARB_N_SRC-1:0] onehot;
    logic [ARB_IDW-1:0]   idx;
  } rr_pick_t;

  // First requester scanning upward from last+1 with wrap. The loop walks
  // from the farthest candidate to the nearest so the nearest one wins.
  function automatic rr_pick_t rr_pick(input logic [ARB_N_SRC-1:0] req,
                                       input logic [ARB_IDW-1:0]   last);
    rr_pick_t r;
    int       cand;
    r.onehot = '0;
    r.idx    = '0;
    for (int i = ARB_N_SRC; i >= 1; i--) begin
      cand = (int'(last) + i) % ARB_N_SRC;
      if (req[cand]) begin
        r.onehot       = '0;
        r.onehot[cand] = 1'b1;
        r.idx          = ARB_IDW'(cand);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/s_egress_arb_fifo2.sv
// Two-entry output FIFO; the head entry drives the output stream directly.
module s_egress_arb_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk_line,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wp, rp;

  // Storage, pointers and occupancy; entries clear on reset so the
  // output bus reads zero until the first push.
  always_ff @(posedge clk_line or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/s_egress_pkt_arbiter.sv
// Packet-atomic round-robin merge of N_SRC AXI-Stream sources into one
// stream; each output beat carries the ID of its source in TUSER.
module s_egress_pkt_arbiter
  import s_egress_arb_pkg::*;
#(
  parameter int BW    = ARB_BW,
  parameter int BWB   = BW / 8,
  parameter int N_SRC = ARB_N_SRC,
  parameter int IDW   = $clog2(N_SRC)
) (
  input  logic                 clk_line,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     src_TVALID,
  output logic [N_SRC-1:0]     src_TREADY,
  input  logic [N_SRC*BW-1:0]  src_TDATA,
  input  logic [N_SRC*BWB-1:0] src_TKEEP,
  input  logic [N_SRC-1:0]     src_TLAST,
  input  logic [N_SRC-1:0]     cfg_src_en,
  output logic                 stream_out_TVALID,
  input  logic                 stream_out_TREADY,
  output logic [BW-1:0]        stream_out_TDATA,
  output logic [BWB-1:0]       stream_out_TKEEP,
  output logic                 stream_out_TLAST,
  output logic [IDW-1:0]       stream_out_TUSER,
  output logic                 busy
);

  arb_state_e       state;
  logic [IDW-1:0]   grant, last_grant;
  logic [N_SRC-1:0] grant_oh, req;
  rr_pick_t         pick;
  logic [1:0]       fifo_count;
  logic             fifo_full, fifo_empty, has_room, push, pop;
  beat_t            wr_beat, rd_beat;

  assign req  = src_TVALID & cfg_src_en;
  assign pick = rr_pick(req, last_grant);

  // Ready comes only from registered state, never from stream_out_TREADY.
  assign has_room   = (fifo_count != 2'd2);
  assign src_TREADY = (state == ARB_XFER && has_room) ? grant_oh : '0;
  assign push       = |(src_TVALID & src_TREADY);
  assign pop        = ~fifo_empty & stream_out_TREADY;
  assign busy       = (state == ARB_XFER);

  // Mux the granted source's beat and tag it with the grant.
  always_comb begin
    wr_beat      = '0;
    wr_beat.data = src_TDATA[int'(grant)*BW +: BW];
    wr_beat.keep = src_TKEEP[int'(grant)*BWB +: BWB];
    wr_beat.last = src_TLAST[grant];
    wr_beat.id   = grant;
  end

  // Arbitration FSM: pick in IDLE, hold the grant until TLAST is accepted.
  always_ff @(posedge clk_line or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      grant_oh   <= '0;
      last_grant <= IDW'(N_SRC - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            grant    <= pick.idx;
            grant_oh <= pick.onehot;
            state    <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (push && src_TLAST[grant]) begin
            last_grant <= grant;
            grant_oh   <= '0;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  s_egress_arb_fifo2 #(.W($bits(beat_t))) u_fifo (
    .clk_line (clk_line),
    .rst      (rst),
    .push     (push),
    .din      (wr_beat),
    .pop      (pop),
    .dout     (rd_beat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign stream_out_TVALID = ~fifo_empty;
  assign stream_out_TDATA  = rd_beat.data;
  assign stream_out_TKEEP  = rd_beat.keep;
  assign stream_out_TLAST  = rd_beat.last;
  assign stream_out_TUSER  = rd_beat.id;

  // Ready is withheld at count 2, so a push can never land on a full FIFO.
  a_no_push_full: assert property (@(posedge clk_line) disable iff (rst)
                                   !(push && fifo_full));

endmodule

// File: tb/tb_s_egress_pkt_arbiter.sv
// Directed bench for the egress packet arbiter.
module tb_s_egress_pkt_arbiter;
  localparam int N = 4, BW = 32, BWB = 4, IDW = 2;

  logic             clk_line = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     src_TVALID = '0, src_TREADY, src_TLAST = '0, cfg_src_en = '1;
  logic [N*BW-1:0]  src_TDATA = '0;
  logic [N*BWB-1:0] src_TKEEP = '0;
  logic             stream_out_TVALID, stream_out_TREADY = 1'b1, stream_out_TLAST, busy;
  logic [BW-1:0]    stream_out_TDATA;
  logic [BWB-1:0]   stream_out_TKEEP;
  logic [IDW-1:0]   stream_out_TUSER;

  s_egress_pkt_arbiter dut (
    .clk_line(clk_line), .rst(rst),
    .src_TVALID(src_TVALID), .src_TREADY(src_TREADY), .src_TDATA(src_TDATA),
    .src_TKEEP(src_TKEEP), .src_TLAST(src_TLAST), .cfg_src_en(cfg_src_en),
    .stream_out_TVALID(stream_out_TVALID), .stream_out_TREADY(stream_out_TREADY),
    .stream_out_TDATA(stream_out_TDATA), .stream_out_TKEEP(stream_out_TKEEP),
    .stream_out_TLAST(stream_out_TLAST), .stream_out_TUSER(stream_out_TUSER),
    .busy(busy)
  );

  always #5 clk_line = ~clk_line;

  int tests = 0, fails = 0, cyc = 0;
  int plen[N], pkts_left[N], pkt_no[N], beat_no[N], acc_cnt[N];
  bit rdy_toggle;

  logic [31:0] oq_data[$];
  logic [3:0]  oq_keep[$];
  logic        oq_last[$];
  logic [1:0]  oq_user[$];
  int          oq_cyc[$];

  // Beat payload: 0xC0 | src | packet | beat; last beat has keep 0x3.
  function automatic logic [31:0] pat(int s, int p, int b);
    return 32'hC000_0000 | (32'(s) << 16) | (32'(p) << 8) | 32'(b);
  endfunction

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      src_TVALID[s]          = (pkts_left[s] > 0);
      src_TDATA[s*BW +: BW]  = pat(s, pkt_no[s], beat_no[s]);
      src_TLAST[s]           = (beat_no[s] == plen[s] - 1);
      src_TKEEP[s*BWB +: BWB] = (beat_no[s] == plen[s] - 1) ? 4'h3 : 4'hF;
    end
    stream_out_TREADY = rdy_toggle ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < N; s++) begin
      plen[s] = 1; pkts_left[s] = 0; pkt_no[s] = 0; beat_no[s] = 0; acc_cnt[s] = 0;
    end
    oq_data.delete(); oq_keep.delete(); oq_last.delete(); oq_user.delete(); oq_cyc.delete();
  endtask

  // Record handshakes mid-cycle, then advance sources just after the edge.
  task automatic cycle();
    @(negedge clk_line);
    if (!rst) begin
      for (int s = 0; s < N; s++)
        if (src_TVALID[s] && src_TREADY[s]) begin
          acc_cnt[s]++;
          beat_no[s]++;
          if (beat_no[s] == plen[s]) begin
            beat_no[s] = 0; pkt_no[s]++; pkts_left[s]--;
          end
        end
      if (stream_out_TVALID && stream_out_TREADY) begin
        oq_data.push_back(stream_out_TDATA); oq_keep.push_back(stream_out_TKEEP);
        oq_last.push_back(stream_out_TLAST); oq_user.push_back(stream_out_TUSER);
        oq_cyc.push_back(cyc);
      end
    end
    @(posedge clk_line); #1;
    cyc++;
    drive();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_clear();
    cfg_src_en = 4'hF;
    rdy_toggle = 1'b0;
    drive();
    repeat (2) @(posedge clk_line);
    #1;
    rst = 1'b0;
    drive();
  endtask

  task automatic check_reset_vals(string tag);
    tests++;
    if (stream_out_TVALID !== 1'b0 || stream_out_TLAST !== 1'b0 || busy !== 1'b0 ||
        src_TREADY !== 4'h0 || stream_out_TDATA !== 32'h0 || stream_out_TKEEP !== 4'h0 ||
        stream_out_TUSER !== 2'h0) begin
      fails++;
      $display("FAIL %s: got vld=%b last=%b busy=%b rdy=%h data=%h keep=%h user=%h, want all zero",
               tag, stream_out_TVALID, stream_out_TLAST, busy, src_TREADY,
               stream_out_TDATA, stream_out_TKEEP, stream_out_TUSER);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_vals("reset_values");
    cycle();
    tests++;
    if (stream_out_TVALID !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: vld=%b busy=%b, want 0 0", stream_out_TVALID, busy);
    end
  endtask

  task automatic test_single_src();
    bit          e_busy[5] = '{1, 1, 1, 0, 0};
    bit          e_vld[5]  = '{0, 1, 1, 1, 0};
    logic [31:0] e_data[5] = '{32'h0, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'h0};
    logic [3:0]  e_keep[5] = '{4'h0, 4'hF, 4'hF, 4'h3, 4'h0};
    bit          e_last[5] = '{0, 0, 0, 1, 0};
    apply_reset();
    plen[0] = 3; pkts_left[0] = 1;
    drive();
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests++;
      if (busy !== e_busy[k] || stream_out_TVALID !== e_vld[k] ||
          (e_vld[k] && (stream_out_TDATA !== e_data[k] || stream_out_TKEEP !== e_keep[k] ||
                        stream_out_TLAST !== e_last[k] || stream_out_TUSER !== 2'd0))) begin
        fails++;
        $display("FAIL single_src step%0d: busy=%b vld=%b data=%h keep=%h last=%b user=%0d, want busy=%b vld=%b data=%h keep=%h last=%b user=0",
                 k, busy, stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST,
                 stream_out_TUSER, e_busy[k], e_vld[k], e_data[k], e_keep[k], e_last[k]);
      end
      if (k == 0) begin
        tests++;
        if (src_TREADY !== 4'b0001) begin
          fails++;
          $display("FAIL single_src_ready: got %b want 0001", src_TREADY);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int p, s;
    apply_reset();
    for (int i = 0; i < N; i++) begin plen[i] = 2; pkts_left[i] = 2; end
    drive();
    for (int k = 0; k < 60 && oq_data.size() < 16; k++) cycle();
    tests++;
    if (oq_data.size() != 16) begin
      fails++;
      $display("FAIL rr_count: got %0d beats want 16", oq_data.size());
    end else
      for (int i = 0; i < 16; i++) begin
        p = i / 2; s = p % 4;
        tests++;
        if (oq_data[i] !== pat(s, p / 4, i % 2) || oq_user[i] !== 2'(s) || oq_last[i] !== 1'(i % 2)) begin
          fails++;
          $display("FAIL rr_beat%0d: data=%h user=%0d last=%b want data=%h user=%0d last=%0d",
                   i, oq_data[i], oq_user[i], oq_last[i], pat(s, p / 4, i % 2), s, i % 2);
        end
      end
  endtask

  task automatic test_backpressure();
    int  occ;
    bit  saw_full = 0;
    apply_reset();
    rdy_toggle = 1'b1;
    plen[1] = 5; pkts_left[1] = 1;
    drive();
    for (int k = 0; k < 40; k++) begin
      cycle();
      occ = acc_cnt[1] - oq_data.size();
      if (occ == 2) begin
        saw_full = 1;
        tests++;
        if (src_TREADY[1] !== 1'b0) begin
          fails++;
          $display("FAIL bp_ready_full: src_TREADY[1]=%b with 2 beats held, want 0", src_TREADY[1]);
        end
      end
      if (oq_data.size() == 5 && occ == 0) break;
    end
    tests++;
    if (!saw_full) begin
      fails++;
      $display("FAIL bp_fill: fifo never reached 2 entries, want it to");
    end
    tests++;
    if (oq_data.size() != 5) begin
      fails++;
      $display("FAIL bp_count: got %0d beats want 5", oq_data.size());
    end else
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (oq_data[i] !== pat(1, 0, i) || oq_user[i] !== 2'd1 || oq_last[i] !== (i == 4) ||
            oq_keep[i] !== ((i == 4) ? 4'h3 : 4'hF)) begin
          fails++;
          $display("FAIL bp_beat%0d: data=%h user=%0d last=%b keep=%h want data=%h user=1 last=%0d",
                   i, oq_data[i], oq_user[i], oq_last[i], oq_keep[i], pat(1, 0, i), i == 4);
        end
      end
  endtask

  task automatic test_mask();
    logic [1:0] e_user[9] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [1:0] e_u2[5]   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    bit         e_l2[5]   = '{0, 0, 1, 1, 1};
    apply_reset();
    cfg_src_en = 4'b1011;
    for (int i = 0; i < N; i++) begin plen[i] = 1; pkts_left[i] = 3; end
    drive();
    for (int k = 0; k < 30; k++) cycle();
    tests++;
    if (oq_data.size() != 9 || acc_cnt[2] != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mask_count: beats=%0d src2=%0d busy=%b want 9 0 0", oq_data.size(), acc_cnt[2], busy);
    end else
      for (int i = 0; i < 9; i++) begin
        tests++;
        if (oq_user[i] !== e_user[i]) begin
          fails++;
          $display("FAIL mask_order%0d: user=%0d want %0d", i, oq_user[i], e_user[i]);
        end
      end
    // Disable src0 mid-packet: its packet finishes, its next one is skipped.
    apply_reset();
    cfg_src_en = 4'b0011;
    plen[0] = 3; pkts_left[0] = 2; plen[1] = 1; pkts_left[1] = 2;
    drive();
    cycle();
    cfg_src_en = 4'b0010;
    for (int k = 0; k < 20; k++) cycle();
    tests++;
    if (oq_data.size() != 5 || acc_cnt[0] != 3) begin
      fails++;
      $display("FAIL mask_midpkt_count: beats=%0d src0=%0d want 5 3", oq_data.size(), acc_cnt[0]);
    end else
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (oq_user[i] !== e_u2[i] || oq_last[i] !== e_l2[i]) begin
          fails++;
          $display("FAIL mask_midpkt%0d: user=%0d last=%b want %0d %0d", i, oq_user[i], oq_last[i], e_u2[i], e_l2[i]);
        end
      end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    plen[0] = 4; pkts_left[0] = 2;
    drive();
    for (int k = 0; k < 30 && acc_cnt[0] < 6; k++) cycle();
    tests++;
    if (acc_cnt[0] != 6 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_setup: src0 beats=%0d busy=%b want 6 1", acc_cnt[0], busy);
    end
    rst = 1'b1;
    #1;
    check_reset_vals("rstmid_async");
    model_clear();
    drive();
    @(posedge clk_line); #1;
    rst = 1'b0;
    pkts_left[0] = 1; pkts_left[1] = 1;
    drive();
    for (int k = 0; k < 10; k++) cycle();
    tests++;
    if (oq_user.size() != 2 || oq_user[0] !== 2'd0 || oq_user[1] !== 2'd1) begin
      fails++;
      $display("FAIL rstmid_first_grant: beats=%0d first_user=%0d want 2 beats, first 0",
               oq_user.size(), (oq_user.size() > 0) ? int'(oq_user[0]) : -1);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    plen[3] = 1; pkts_left[3] = 4;
    drive();
    for (int k = 0; k < 20; k++) cycle();
    tests++;
    if (oq_data.size() != 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d beats want 4", oq_data.size());
    end else
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (oq_user[i] !== 2'd3 || oq_last[i] !== 1'b1 || oq_data[i] !== pat(3, i, 0) ||
            (i > 0 && oq_cyc[i] - oq_cyc[i-1] != 2)) begin
          fails++;
          $display("FAIL b2b_beat%0d: user=%0d last=%b data=%h gap=%0d want 3 1 %h gap 2",
                   i, oq_user[i], oq_last[i], oq_data[i], (i > 0) ? oq_cyc[i] - oq_cyc[i-1] : 2, pat(3, i, 0));
        end
      end
  endtask

  initial begin
    test_reset();
    test_single_src();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
